morse_entry_ctrl: RTL and testbench

Sequencer that sits between the debounced Morse push-buttons (dot, dash, commit, clear; each a one-cycle pulse from `morsedebouncer`) and the character decoder/display path. It accumulates dot/dash symbols into a letter buffer and closes a letter on an explicit commit or an inactivity timeout. It then presents the completed code to the downstream decoder through a valid/ready handshake.

---
 rtl/morse_pkg.sv | 20 ++
 rtl/morse_entry_ctrl.sv | 155 +++++++++++++++
 tb/tb_morse_entry_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and constants for the Morse entry path
package morse_pkg;

    // Entry sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Default maximum symbols per letter
    localparam int MAX_SYM_DEF = 5;

    // Width of symbol-count fields (cur_len, code_len)
    localparam int LEN_W = 3;

    // A presented code of length zero denotes a word space
    localparam logic [LEN_W-1:0] WORD_SPACE_LEN = '0;

endpackage

// File: rtl/morse_entry_ctrl.sv
// rtl/morse_entry_ctrl.sv - accumulates dot/dash pulses into letters and presents them via valid/ready
module morse_entry_ctrl
    import morse_pkg::*;
#(
    parameter int MAX_SYM     = MAX_SYM_DEF,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dot_p,
    input  logic               dash_p,
    input  logic               commit_p,
    input  logic               clear_p,
    output logic [MAX_SYM-1:0] code_bits,
    output logic [LEN_W-1:0]   code_len,
    output logic               code_err,
    output logic               code_valid,
    input  logic               code_ready,
    output logic [LEN_W-1:0]   cur_len,
    output logic               lost_p
);

    localparam logic [LEN_W-1:0]   MAX_LEN = LEN_W'(MAX_SYM);
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [MAX_SYM-1:0] ONE_BIT = MAX_SYM'(1);

    state_t             state, state_n;
    logic [MAX_SYM-1:0] bits, bits_n;
    logic [LEN_W-1:0]   len_n;
    logic               err, err_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [MAX_SYM-1:0] cbits_n;
    logic [LEN_W-1:0]   clen_n;
    logic               cerr_n;
    logic               lost_n;
    logic               sym;
    logic               full;

    assign sym        = dot_p | dash_p;
    assign full       = (cur_len >= MAX_LEN);
    // Valid is decoded straight from state so an async reset drops it immediately
    assign code_valid = (state == S_HOLD);

    // Register all sequencer state; async reset discards any letter in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bits      <= '0;
            cur_len   <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            code_bits <= '0;
            code_len  <= '0;
            code_err  <= 1'b0;
            lost_p    <= 1'b0;
        end else begin
            state     <= state_n;
            bits      <= bits_n;
            cur_len   <= len_n;
            err       <= err_n;
            cnt       <= cnt_n;
            code_bits <= cbits_n;
            code_len  <= clen_n;
            code_err  <= cerr_n;
            lost_p    <= lost_n;
        end
    end

    // Next-state logic: clear > commit > dash > dot, one action per cycle
    always_comb begin
        state_n = state;
        bits_n  = bits;
        len_n   = cur_len;
        err_n   = err;
        cnt_n   = cnt;
        cbits_n = code_bits;
        clen_n  = code_len;
        cerr_n  = code_err;
        lost_n  = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (clear_p) begin
                    // Nothing buffered; clear has no effect
                end else if (commit_p) begin
                    cbits_n = '0;
                    clen_n  = WORD_SPACE_LEN;
                    cerr_n  = 1'b0;
                    state_n = S_HOLD;
                end else if (sym) begin
                    bits_n  = dash_p ? ONE_BIT : '0;
                    len_n   = LEN_W'(1);
                    state_n = S_ENTRY;
                    lost_n  = dot_p & dash_p;
                end
            end

            S_ENTRY: begin
                cnt_n = cnt + CNT_W'(1);
                if (clear_p) begin
                    bits_n  = '0;
                    len_n   = '0;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else if (commit_p) begin
                    cbits_n = bits;
                    clen_n  = cur_len;
                    cerr_n  = err;
                    cnt_n   = '0;
                    state_n = S_HOLD;
                end else if (sym) begin
                    // A symbol arriving on the timeout cycle still counts as activity
                    cnt_n = '0;
                    if (full) begin
                        err_n  = 1'b1;
                        lost_n = 1'b1;
                    end else begin
                        bits_n = bits | (dash_p ? (ONE_BIT << cur_len) : '0);
                        len_n  = cur_len + LEN_W'(1);
                        lost_n = dot_p & dash_p;
                    end
                end else if (cnt == TO_LAST) begin
                    cbits_n = bits;
                    clen_n  = cur_len;
                    cerr_n  = err;
                    cnt_n   = '0;
                    state_n = S_HOLD;
                end
            end

            S_HOLD: begin
                cnt_n  = '0;
                lost_n = dot_p | dash_p | commit_p | clear_p;
                if (code_ready) begin
                    bits_n  = '0;
                    len_n   = '0;
                    err_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
                bits_n  = '0;
                len_n   = '0;
                err_n   = 1'b0;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_morse_entry_ctrl.sv
// tb/tb_morse_entry_ctrl.sv - directed self-checking bench for morse_entry_ctrl
module tb_morse_entry_ctrl;

    logic       clk;
    logic       rst_n;
    logic       dot_p, dash_p, commit_p, clear_p;
    logic [4:0] code_bits;
    logic [2:0] code_len;
    logic       code_err;
    logic       code_valid;
    logic       code_ready;
    logic [2:0] cur_len;
    logic       lost_p;

    int checks = 0;
    int errors = 0;

    morse_entry_ctrl #(
        .MAX_SYM    (5),
        .TIMEOUT_CYC(20),
        .CNT_W      (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dot_p     (dot_p),
        .dash_p    (dash_p),
        .commit_p  (commit_p),
        .clear_p   (clear_p),
        .code_bits (code_bits),
        .code_len  (code_len),
        .code_err  (code_err),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .cur_len   (cur_len),
        .lost_p    (lost_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present inputs for one rising edge; returns at the following falling edge
    task automatic pulse(input logic d, input logic da, input logic cm, input logic cl);
        dot_p    = d;
        dash_p   = da;
        commit_p = cm;
        clear_p  = cl;
        @(negedge clk);
        dot_p    = 1'b0;
        dash_p   = 1'b0;
        commit_p = 1'b0;
        clear_p  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dot_p = 1'b0; dash_p = 1'b0; commit_p = 1'b0; clear_p = 1'b0;
        code_ready = 1'b0;
        #12;
        checks++;
        if ({code_valid, code_len, code_err, cur_len, lost_p, code_bits} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b len=%0d err=%b cur=%0d lost=%b bits=%b, want all 0",
                     code_valid, code_len, code_err, cur_len, lost_p, code_bits);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_letter_a();
        code_ready = 1'b1;
        pulse(1, 0, 0, 0);
        checks++;
        if (cur_len !== 3'd1) begin errors++; $display("FAIL a_len1: got %0d want 1", cur_len); end
        pulse(0, 1, 0, 0);
        checks++;
        if (cur_len !== 3'd2) begin errors++; $display("FAIL a_len2: got %0d want 2", cur_len); end
        pulse(0, 0, 1, 0);
        checks++;
        if (code_valid !== 1'b1 || code_bits !== 5'b00010 || code_len !== 3'd2 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL a_code: got v=%b bits=%b len=%0d err=%b want v=1 bits=00010 len=2 err=0",
                     code_valid, code_bits, code_len, code_err);
        end
        @(negedge clk);
        checks++;
        if (code_valid !== 1'b0 || cur_len !== 3'd0) begin
            errors++;
            $display("FAIL a_after: got v=%b cur=%0d want v=0 cur=0", code_valid, cur_len);
        end
    endtask

    task automatic test_auto_commit();
        int first;
        code_ready = 1'b1;
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            if (code_valid === 1'b1) begin
                first = k - 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (first != 20) begin errors++; $display("FAIL auto_latency: got %0d want 20", first); end
        checks++;
        if (code_bits !== 5'b00111 || code_len !== 3'd3 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL auto_code: got bits=%b len=%0d err=%b want bits=00111 len=3 err=0",
                     code_bits, code_len, code_err);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int lost_cnt;
        code_ready = 1'b1;
        lost_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            pulse(1, 0, 0, 0);
            if (lost_p === 1'b1) lost_cnt++;
        end
        checks++;
        if (lost_cnt != 2) begin errors++; $display("FAIL ovf_lost: got %0d want 2", lost_cnt); end
        pulse(0, 0, 1, 0);
        checks++;
        if (code_valid !== 1'b1 || code_len !== 3'd5 || code_err !== 1'b1 || code_bits !== 5'b00000) begin
            errors++;
            $display("FAIL ovf_code: got v=%b len=%0d err=%b bits=%b want v=1 len=5 err=1 bits=00000",
                     code_valid, code_len, code_err, code_bits);
        end
        @(negedge clk);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        checks++;
        if (code_valid !== 1'b1 || code_len !== 3'd1 || code_err !== 1'b0 || code_bits !== 5'b00001) begin
            errors++;
            $display("FAIL ovf_next: got v=%b len=%0d err=%b bits=%b want v=1 len=1 err=0 bits=00001",
                     code_valid, code_len, code_err, code_bits);
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        code_ready = 1'b0;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            pulse((i % 2) == 0, 0, 0, 0);
            checks++;
            if (code_valid !== 1'b1 || code_bits !== 5'b00010 || code_len !== 3'd3 ||
                lost_p !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b bits=%b len=%0d lost=%b want v=1 bits=00010 len=3 lost=%b",
                         i, code_valid, code_bits, code_len, lost_p, (i % 2) == 0);
            end
        end
        code_ready = 1'b1;
        pulse(1, 0, 0, 0);
        checks++;
        if (code_valid !== 1'b0 || cur_len !== 3'd0 || lost_p !== 1'b1) begin
            errors++;
            $display("FAIL bp_transfer: got v=%b cur=%0d lost=%b want v=0 cur=0 lost=1",
                     code_valid, cur_len, lost_p);
        end
        @(negedge clk);
        checks++;
        if (code_valid !== 1'b0 || cur_len !== 3'd0 || lost_p !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got v=%b cur=%0d lost=%b want v=0 cur=0 lost=0",
                     code_valid, cur_len, lost_p);
        end
    endtask

    task automatic test_simultaneous();
        code_ready = 1'b1;
        pulse(1, 1, 0, 0);
        checks++;
        if (cur_len !== 3'd1 || lost_p !== 1'b1) begin
            errors++;
            $display("FAIL sim_dotdash: got cur=%0d lost=%b want cur=1 lost=1", cur_len, lost_p);
        end
        pulse(0, 0, 1, 0);
        checks++;
        if (code_valid !== 1'b1 || code_bits !== 5'b00001 || code_len !== 3'd1) begin
            errors++;
            $display("FAIL sim_dash_kept: got v=%b bits=%b len=%0d want v=1 bits=00001 len=1",
                     code_valid, code_bits, code_len);
        end
        @(negedge clk);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 1);
        checks++;
        if (cur_len !== 3'd0 || lost_p !== 1'b0 || code_valid !== 1'b0) begin
            errors++;
            $display("FAIL sim_clear: got cur=%0d lost=%b v=%b want cur=0 lost=0 v=0",
                     cur_len, lost_p, code_valid);
        end
        pulse(0, 0, 1, 0);
        checks++;
        if (code_valid !== 1'b1 || code_len !== 3'd0 || code_bits !== 5'b00000 || code_err !== 1'b0) begin
            errors++;
            $display("FAIL sim_wordspace: got v=%b len=%0d bits=%b err=%b want v=1 len=0 bits=00000 err=0",
                     code_valid, code_len, code_bits, code_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        code_ready = 1'b0;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        checks++;
        if (cur_len !== 3'd3) begin errors++; $display("FAIL rst_pre: got cur=%0d want 3", cur_len); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cur_len !== 3'd0 || code_valid !== 1'b0 || lost_p !== 1'b0) begin
            errors++;
            $display("FAIL rst_entry: got cur=%0d v=%b lost=%b want 0 0 0", cur_len, code_valid, lost_p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        checks++;
        if (code_valid !== 1'b1 || code_len !== 3'd1) begin
            errors++;
            $display("FAIL rst_prehold: got v=%b len=%0d want v=1 len=1", code_valid, code_len);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (code_valid !== 1'b0 || code_len !== 3'd0 || code_bits !== 5'd0 || code_err !== 1'b0 ||
            cur_len !== 3'd0) begin
            errors++;
            $display("FAIL rst_hold: got v=%b len=%0d bits=%b err=%b cur=%0d want all 0",
                     code_valid, code_len, code_bits, code_err, cur_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_auto_commit();
        test_overflow();
        test_back_pressure();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
